// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring 32-bit divider producing {HI=remainder, LO=quotient}
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_div,
  input  logic        start,
  input  logic        annul,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {IDLE, ZERO, ON, END} state_t;

  state_t      state, state_n;
  logic        accept;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] dvsr;
  logic        neg_q, neg_r;

  logic [31:0] mag_a, mag_b;
  logic [64:0] shifted, work_n;
  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    ready   = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          accept  = 1'b1;
          busy    = 1'b1;
          state_n = (b == 32'd0) ? ZERO : ON;
        end
      end
      ZERO: begin
        busy    = 1'b1;
        state_n = annul ? IDLE : END;
      end
      ON: begin
        busy = 1'b1;
        if (annul)              state_n = IDLE;
        else if (cnt == 6'd31)  state_n = END;
      end
      END: begin
        ready   = !annul;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // 0x80000000 negates to itself, which read as unsigned is the correct 2^31 magnitude
  assign mag_a = (signed_div && a[31]) ? -a : a;
  assign mag_b = (signed_div && b[31]) ? -b : b;

  always_comb begin
    shifted = work << 1;
    trial   = shifted[64:32] - {1'b0, dvsr};
    work_n  = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
    quo_fix = neg_q ? -work_n[31:0]  : work_n[31:0];
    rem_fix = neg_r ? -work_n[63:32] : work_n[63:32];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= 6'd0;
      work   <= 65'd0;
      dvsr   <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 64'h0;
    end else if (accept) begin
      cnt    <= 6'd0;
      work   <= {33'd0, mag_a};
      dvsr   <= mag_b;
      neg_q  <= signed_div && (a[31] ^ b[31]);
      neg_r  <= signed_div && a[31];
    end else if (state == ON && !annul) begin
      work <= work_n;
      cnt  <= cnt + 6'd1;
      if (cnt == 6'd31) result <= {rem_fix, quo_fix};
    end else if (state == ZERO && !annul) begin
      result <= 64'h0;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with randomized operands
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        signed_div = 1'b0, start = 1'b0, annul = 1'b0;
  logic        busy, ready;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;

  logic [63:0] exp_q[$];
  int          exp_t[$];

  div_unit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div),
    .start(start), .annul(annul), .busy(busy), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    if (y == 32'd0) return 64'h0;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  // monitor: every ready pulse must match the oldest expectation, in value and cycle
  initial begin
    forever begin
      @(negedge clk);
      if (ready) begin
        if (exp_q.size() == 0) begin
          chk("ready_unexpected", {63'd0, ready}, 64'd0);
        end else begin
          chk("result", result, exp_q.pop_front());
          chk("ready_cycle", 64'(cyc), 64'(exp_t.pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input bit push);
    @(negedge clk);
    a = x; b = y; signed_div = s; start = 1'b1;
    #1 chk("busy_issue", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    c0 = cyc;
    if (push) begin
      exp_q.push_back(model(x, y, s));
      exp_t.push_back(c0 + ((y == 32'd0) ? 1 : 32));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout_ready", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      exp_t.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errs;
    logic [31:0] x, y;
    logic s;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_result", result, 64'h0);
    rst = 1'b1;
    @(posedge clk);

    // 100/7 with busy trace, start re-asserted and operands scrambled while ON
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    errs = 0;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      if (busy !== (k < 32)) errs++;
      if (k < 20) begin
        a = $urandom; b = $urandom; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_trace_100_7", 64'(errs), 64'd0);
    wait_idle();

    issue(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1); wait_idle();
    issue(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1); wait_idle();
    issue(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b1); wait_idle();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1); wait_idle();
    issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1); wait_idle();

    // divide by zero: busy only in the issue and ZERO cycles
    issue(32'd1234, 32'd0, 1'b1, 1'b1);
    errs = 0;
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      if (busy !== (k < 1)) errs++;
    end
    chk("busy_trace_zero", 64'(errs), 64'd0);
    wait_idle();

    // cancel on iteration 10, then restart at once
    issue(32'd500, 32'd3, 1'b0, 1'b1); wait_idle();
    issue(32'd1234, 32'd5, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    chk("annul_busy", {63'd0, busy}, 64'd0);
    chk("annul_result_held", result, model(32'd500, 32'd3, 1'b0));
    issue(32'd1000, 32'd10, 1'b0, 1'b1); wait_idle();

    // annul during END: no ready, but result updates
    issue(32'd20, 32'd3, 1'b0, 1'b0);
    repeat (32) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("end_annul_ready", {63'd0, ready}, 64'd0);
    chk("end_annul_busy", {63'd0, busy}, 64'd0);
    chk("end_annul_result", result, model(32'd20, 32'd3, 1'b0));
    @(posedge clk);
    #1 annul = 1'b0;

    // reset on iteration 20
    issue(32'd77, 32'd7, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_result", result, 64'h0);
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      x = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      s = 1'($urandom_range(0, 1));
      issue(x, y, s, 1'b1);
      if (y != 32'd0) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          a = $urandom; b = $urandom; signed_div = 1'($urandom); start = 1'($urandom);
        end
        start = 1'b0;
      end
      wait_idle();
    end

    repeat (40) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
